// File: rtl/reg_status_file_pkg.sv
// Shared constants and types for the Tomasulo register/rename-status file.
// ROB_INDEX_BIT may be supplied by the ROB build; a local default keeps this slice standalone.
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

package reg_status_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_CNT   = 32;
  localparam int REG_IDX_W = 5;
  localparam int TAG_W     = `ROB_INDEX_BIT;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0]     rob_tag_t;
  typedef logic [XLEN-1:0]      xlen_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } rename_t;

  // A commit can only retire the rename it names; younger renames keep their tag.
  function automatic logic tag_hit(rename_t stat, rob_tag_t rob_id);
    return stat.busy && (stat.tag == rob_id);
  endfunction

endpackage

// File: rtl/reg_status_file_rf_read_port.sv
// rf_read_port: one combinational operand lookup with same-cycle commit bypass.
// Instantiated once per source operand by reg_status_file.
module rf_read_port
  import reg_status_file_pkg::*;
(
  input  logic                    rdy_in,
  input  reg_idx_t                idx_i,
  input  xlen_t   [REG_CNT-1:0]   reg_val_i,
  input  rename_t [REG_CNT-1:0]   reg_stat_i,
  input  reg_idx_t                com_rd_i,
  input  xlen_t                   com_val_i,
  input  rob_tag_t                com_rob_id_i,
  output xlen_t                   val_o,
  output logic                    busy_o,
  output rob_tag_t                tag_o
);

  rename_t stat_sel;
  logic    bypass_hit;

  assign stat_sel   = reg_stat_i[idx_i];
  // Bypass only when the commit will really land this cycle, so a frozen core reads pure state.
  assign bypass_hit = rdy_in && (com_rd_i == idx_i) && tag_hit(stat_sel, com_rob_id_i);

  always_comb begin
    val_o  = '0;
    busy_o = 1'b0;
    tag_o  = '0;
    if (idx_i != '0) begin
      if (bypass_hit) begin
        val_o = com_val_i;
      end else begin
        val_o  = reg_val_i[idx_i];
        busy_o = stat_sel.busy;
        tag_o  = stat_sel.busy ? stat_sel.tag : '0;
      end
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// reg_status_file: architectural registers plus per-register busy/ROB-tag rename status.
// Optional RF_TRACE_EN adds a bypass-free debug read port and a committed-write counter.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_n_in,
  input  logic     rdy_in,
  input  logic     clear_in,
  input  logic     iss_valid,
  input  reg_idx_t iss_rd,
  input  rob_tag_t iss_rob_id,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  output xlen_t    rs1_val,
  output logic     rs1_busy,
  output rob_tag_t rs1_tag,
  output xlen_t    rs2_val,
  output logic     rs2_busy,
  output rob_tag_t rs2_tag,
  input  reg_idx_t com_rd,
  input  xlen_t    com_val,
  input  rob_tag_t com_rob_id
`ifdef RF_TRACE_EN
  ,
  input  reg_idx_t    dbg_idx,
  output xlen_t       dbg_val,
  output logic [31:0] dbg_wr_cnt
`endif
);

  xlen_t   [REG_CNT-1:0] val_q, val_d;
  rename_t [REG_CNT-1:0] stat_q, stat_d;

  logic com_en;
  logic iss_en;

  assign com_en = rdy_in && (com_rd != '0);
  assign iss_en = rdy_in && iss_valid && (iss_rd != '0) && !clear_in;

  // Commit first, then issue/clear on top: a same-rd issue wins the status, the commit wins the value.
  always_comb begin
    val_d  = val_q;
    stat_d = stat_q;
    if (com_en) begin
      val_d[com_rd] = com_val;
      if (stat_q[com_rd].tag == com_rob_id) begin
        stat_d[com_rd] = '0;
      end
    end
    if (rdy_in && clear_in) begin
      stat_d = '0;
    end else if (iss_en) begin
      stat_d[iss_rd] = '{busy: 1'b1, tag: iss_rob_id};
    end
    val_d[0]  = '0;
    stat_d[0] = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      val_q  <= '0;
      stat_q <= '0;
    end else begin
      val_q  <= val_d;
      stat_q <= stat_d;
    end
  end

  rf_read_port u_rs1_port (
    .rdy_in       (rdy_in),
    .idx_i        (rs1_idx),
    .reg_val_i    (val_q),
    .reg_stat_i   (stat_q),
    .com_rd_i     (com_rd),
    .com_val_i    (com_val),
    .com_rob_id_i (com_rob_id),
    .val_o        (rs1_val),
    .busy_o       (rs1_busy),
    .tag_o        (rs1_tag)
  );

  rf_read_port u_rs2_port (
    .rdy_in       (rdy_in),
    .idx_i        (rs2_idx),
    .reg_val_i    (val_q),
    .reg_stat_i   (stat_q),
    .com_rd_i     (com_rd),
    .com_val_i    (com_val),
    .com_rob_id_i (com_rob_id),
    .val_o        (rs2_val),
    .busy_o       (rs2_busy),
    .tag_o        (rs2_tag)
  );

`ifdef RF_TRACE_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // The counter holds through a flush cycle even though the commit value itself is written.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (com_en && !clear_in) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign dbg_val    = val_q[dbg_idx];
  assign dbg_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename, commit bypass, stale commits, flush, x0 and freeze.
// Debug-port checks compile in only when RF_TRACE_EN is defined.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

  logic     clk_in = 1'b0;
  logic     rst_n_in;
  logic     rdy_in;
  logic     clear_in;
  logic     iss_valid;
  reg_idx_t iss_rd;
  rob_tag_t iss_rob_id;
  reg_idx_t rs1_idx, rs2_idx;
  xlen_t    rs1_val, rs2_val;
  logic     rs1_busy, rs2_busy;
  rob_tag_t rs1_tag, rs2_tag;
  reg_idx_t com_rd;
  xlen_t    com_val;
  rob_tag_t com_rob_id;
`ifdef RF_TRACE_EN
  reg_idx_t    dbg_idx;
  xlen_t       dbg_val;
  logic [31:0] dbg_wr_cnt;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;
  xlen_t expVal [0:8];

  always #5 clk_in = ~clk_in;

  reg_status_file dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .clear_in   (clear_in),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_rob_id (iss_rob_id),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_val    (rs1_val),
    .rs1_busy   (rs1_busy),
    .rs1_tag    (rs1_tag),
    .rs2_val    (rs2_val),
    .rs2_busy   (rs2_busy),
    .rs2_tag    (rs2_tag),
    .com_rd     (com_rd),
    .com_val    (com_val),
    .com_rob_id (com_rob_id)
`ifdef RF_TRACE_EN
    ,
    .dbg_idx    (dbg_idx),
    .dbg_val    (dbg_val),
    .dbg_wr_cnt (dbg_wr_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input int ird, input int irob,
                               input int crd, input logic [31:0] cval, input int cid);
    iss_valid  = iv;
    iss_rd     = reg_idx_t'(ird);
    iss_rob_id = rob_tag_t'(irob);
    com_rd     = reg_idx_t'(crd);
    com_val    = cval;
    com_rob_id = rob_tag_t'(cid);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    rs1_idx  = '0;
    rs2_idx  = '0;
`ifdef RF_TRACE_EN
    dbg_idx  = '0;
`endif
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    #12;
    rst_n_in = 1'b1;

    rs1_idx = 5'd3;
    #1;
    checkOutput("reset_val", 64'(rs1_val), 64'h0);
    checkOutput("reset_busy", 64'(rs1_busy), 64'h0);

    // Issue x3 -> tag 2; same-cycle read must still see the old status
    tick();
    applyStimulus(1'b1, 3, 2, 0, 32'h0, 0);
    #1;
    checkOutput("same_cycle_issue_busy", 64'(rs1_busy), 64'h0);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    #1;
    checkOutput("x3_busy", 64'(rs1_busy), 64'h1);
    checkOutput("x3_tag", 64'(rs1_tag), 64'h2);
    applyStimulus(1'b0, 0, 0, 3, 32'h55, 2);
    rs2_idx = 5'd3;
    #1;
    checkOutput("bypass_val", 64'(rs1_val), 64'h55);
    checkOutput("bypass_busy", 64'(rs1_busy), 64'h0);
    checkOutput("bypass_rs2_val", 64'(rs2_val), 64'h55);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    #1;
    checkOutput("x3_stored", 64'(rs1_val), 64'h55);
    checkOutput("x3_retired_busy", 64'(rs1_busy), 64'h0);
    checkOutput("x3_retired_tag", 64'(rs1_tag), 64'h0);

    // Two renames of x4, then commit of the older one
    applyStimulus(1'b1, 4, 1, 0, 32'h0, 0);
    tick();
    applyStimulus(1'b1, 4, 5, 0, 32'h0, 0);
    tick();
    applyStimulus(1'b0, 0, 0, 4, 32'h7, 1);
    rs2_idx = 5'd4;
    #1;
    checkOutput("stale_no_bypass_busy", 64'(rs2_busy), 64'h1);
    checkOutput("stale_no_bypass_val", 64'(rs2_val), 64'h0);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    #1;
    checkOutput("x4_val", 64'(rs2_val), 64'h7);
    checkOutput("x4_busy", 64'(rs2_busy), 64'h1);
    checkOutput("x4_tag", 64'(rs2_tag), 64'h5);

    // Issue and commit to x6 in the same cycle
    applyStimulus(1'b1, 6, 3, 6, 32'h9, 0);
    rs1_idx = 5'd6;
    tick();
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    #1;
    checkOutput("x6_busy", 64'(rs1_busy), 64'h1);
    checkOutput("x6_tag", 64'(rs1_tag), 64'h3);
`ifdef RF_TRACE_EN
    dbg_idx = 5'd6;
    #1;
    checkOutput("dbg_x6_val", 64'(dbg_val), 64'h9);
    checkOutput("dbg_wr_cnt", 64'(dbg_wr_cnt), 64'h3);
`endif

    // Rename x1..x8, then flush with a concurrent issue to x2
    expVal = '{32'h0, 32'h0, 32'h0, 32'h55, 32'h7, 32'h0, 32'h9, 32'h0, 32'h0};
    for (int r = 1; r <= 8; r++) begin
      applyStimulus(1'b1, r, r, 0, 32'h0, 0);
      tick();
    end
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    rs1_idx = 5'd8;
    #1;
    checkOutput("x8_busy_pre_clear", 64'(rs1_busy), 64'h1);
    applyStimulus(1'b1, 2, 7, 0, 32'h0, 0);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    for (int r = 1; r <= 8; r++) begin
      rs1_idx = reg_idx_t'(r);
      #1;
      checkOutput($sformatf("clear_busy_x%0d", r), 64'(rs1_busy), 64'h0);
      checkOutput($sformatf("clear_val_x%0d", r), 64'(rs1_val), 64'(expVal[r]));
    end
    rs2_idx = 5'd2;
    #1;
    checkOutput("clear_x2_tag", 64'(rs2_tag), 64'h0);

    // x0 writes ignored
    applyStimulus(1'b1, 0, 4, 0, 32'hFF, 0);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    rs1_idx = 5'd0;
    #1;
    checkOutput("x0_val", 64'(rs1_val), 64'h0);
    checkOutput("x0_busy", 64'(rs1_busy), 64'h0);

    // Frozen core: issue and commit to x9 must not land
    rdy_in = 1'b0;
    applyStimulus(1'b1, 9, 4, 9, 32'h12, 0);
    tick();
    rdy_in = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    rs1_idx = 5'd9;
    #1;
    checkOutput("frozen_x9_busy", 64'(rs1_busy), 64'h0);
    checkOutput("frozen_x9_val", 64'(rs1_val), 64'h0);

    // Async reset mid-cycle with x5 busy
    applyStimulus(1'b1, 5, 6, 0, 32'h0, 0);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 32'h0, 0);
    rs1_idx = 5'd5;
    rs2_idx = 5'd3;
    #1;
    checkOutput("x5_busy_pre_reset", 64'(rs1_busy), 64'h1);
    #1;
    rst_n_in = 1'b0;
    #1;
    checkOutput("async_reset_busy", 64'(rs1_busy), 64'h0);
    checkOutput("async_reset_tag", 64'(rs1_tag), 64'h0);
    checkOutput("async_reset_x3_val", 64'(rs2_val), 64'h0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
